// File: rtl/store_buffer.sv
// Dual-lane store buffer: queues up to two stores per cycle in program order,
// drains one per cycle to memory, and forwards the youngest buffered match to two load lanes.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic                     clk1,
  input  logic                     reset,
  input  logic                     st0_valid,
  input  logic [AW-1:0]            st0_addr,
  input  logic [DW-1:0]            st0_data,
  input  logic                     st1_valid,
  input  logic [AW-1:0]            st1_addr,
  input  logic [DW-1:0]            st1_data,
  output logic                     st_ready,
  input  logic [AW-1:0]            ld0_addr,
  output logic                     ld0_hit,
  output logic [DW-1:0]            ld0_data,
  input  logic [AW-1:0]            ld1_addr,
  output logic                     ld1_hit,
  output logic [DW-1:0]            ld1_data,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = IW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_en0;
  logic          w_en1;
  logic          w_pop;
  logic [1:0]    w_nenq;
  logic [IW-1:0] w_wslot0;
  logic [IW-1:0] w_wslot1;
  logic [IW-1:0] w_head_idx;
  logic [IW-1:0] w_slot [DEPTH];
  logic          w_live [DEPTH];

  assign st_ready   = (CW'(DEPTH) - r_count) >= CW'(2);
  assign w_en0      = st0_valid & st_ready;
  assign w_en1      = st1_valid & st_ready;
  assign w_nenq     = {1'b0, w_en0} + {1'b0, w_en1};
  assign w_head_idx = r_head[IW-1:0];
  assign mem_we     = (r_count != '0);
  assign w_pop      = mem_we & mem_ready;
  assign mem_addr   = mem_we ? r_addr[w_head_idx] : '0;
  assign mem_wdata  = mem_we ? r_data[w_head_idx] : '0;
  assign count      = r_count;
  assign overflow   = r_ovf;

  // Lane 1 lands behind lane 0 only when lane 0 actually takes a slot.
  assign w_wslot0 = r_tail[IW-1:0];
  assign w_wslot1 = w_en0 ? (r_tail[IW-1:0] + IW'(1)) : r_tail[IW-1:0];

  // Entry k of the age order sits k slots after the head; it is live while k < count.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign w_slot[k] = w_head_idx + IW'(k);
    assign w_live[k] = CW'(k) < r_count;
  end

  always_ff @(posedge clk1) begin
    if (w_en0) begin
      r_addr[w_wslot0] <= st0_addr;
      r_data[w_wslot0] <= st0_data;
    end
    if (w_en1) begin
      r_addr[w_wslot1] <= st1_addr;
      r_data[w_wslot1] <= st1_data;
    end
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_nenq);
      r_count <= r_count + CW'(w_nenq) - CW'(w_pop);
      if ((st0_valid | st1_valid) & ~st_ready)
        r_ovf <= 1'b1;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    ld0_hit  = 1'b0;
    ld0_data = '0;
    ld1_hit  = 1'b0;
    ld1_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_live[k] && (r_addr[w_slot[k]] == ld0_addr)) begin
        ld0_hit  = 1'b1;
        ld0_data = r_data[w_slot[k]];
      end
      if (w_live[k] && (r_addr[w_slot[k]] == ld1_addr)) begin
        ld1_hit  = 1'b1;
        ld1_data = r_data[w_slot[k]];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic,
// scored against a queue-based model of the buffered stores.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk1 = 1'b0;
  logic          reset = 1'b0;
  logic          st0_valid = 1'b0, st1_valid = 1'b0;
  logic [AW-1:0] st0_addr = '0, st1_addr = '0, ld0_addr = '0, ld1_addr = '0;
  logic [DW-1:0] st0_data = '0, st1_data = '0;
  logic          st_ready, ld0_hit, ld1_hit, mem_we, overflow;
  logic [DW-1:0] ld0_data, ld1_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ready = 1'b0;
  logic [CW-1:0] count;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk1(clk1), .reset(reset),
    .st0_valid(st0_valid), .st0_addr(st0_addr), .st0_data(st0_data),
    .st1_valid(st1_valid), .st1_addr(st1_addr), .st1_data(st1_data),
    .st_ready(st_ready),
    .ld0_addr(ld0_addr), .ld0_hit(ld0_hit), .ld0_data(ld0_data),
    .ld1_addr(ld1_addr), .ld1_hit(ld1_hit), .ld1_data(ld1_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .overflow(overflow)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } st_t;

  st_t mq[$];       // model of buffer contents, oldest first
  st_t exp_wr[$];   // scoreboard of memory writes still expected
  bit  ovf_m = 1'b0;
  bit  acc_m;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void fwd(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    foreach (mq[i]) if (mq[i].a == a) begin h = 1'b1; d = mq[i].d; end
  endfunction

  // Reference model: state of the buffer as of the most recent edge.
  always @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      mq.delete();
      exp_wr.delete();
      ovf_m = 1'b0;
    end else begin
      acc_m = (DEPTH - mq.size()) >= 2;
      if (mq.size() > 0 && mem_ready) void'(mq.pop_front());
      if (acc_m) begin
        if (st0_valid) begin mq.push_back({st0_addr, st0_data}); exp_wr.push_back({st0_addr, st0_data}); end
        if (st1_valid) begin mq.push_back({st1_addr, st1_data}); exp_wr.push_back({st1_addr, st1_data}); end
      end else if (st0_valid || st1_valid) begin
        ovf_m = 1'b1;
      end
    end
  end

  // Monitor: compare every observable against the model mid-cycle.
  always @(negedge clk1) begin
    logic          h;
    logic [DW-1:0] d;
    chk("count", 64'(count), 64'(mq.size()));
    chk("st_ready", 64'(st_ready), 64'((DEPTH - mq.size()) >= 2));
    chk("overflow", 64'(overflow), 64'(ovf_m));
    chk("mem_we", 64'(mem_we), 64'(mq.size() != 0));
    fwd(ld0_addr, h, d);
    chk("ld0_hit", 64'(ld0_hit), 64'(h));
    chk("ld0_data", 64'(ld0_data), 64'(d));
    fwd(ld1_addr, h, d);
    chk("ld1_hit", 64'(ld1_hit), 64'(h));
    chk("ld1_data", 64'(ld1_data), 64'(d));
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", 64'(mem_we), 64'(0));
      end else begin
        chk("mem_addr", 64'(mem_addr), 64'(exp_wr[0].a));
        chk("mem_wdata", 64'(mem_wdata), 64'(exp_wr[0].d));
        if (mem_ready) void'(exp_wr.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk1);
    #1;
  endtask

  task automatic drive(input logic v0, input int a0, input int d0,
                       input logic v1, input int a1, input int d1);
    st0_valid = v0; st0_addr = AW'(a0); st0_data = DW'(d0);
    st1_valid = v1; st1_addr = AW'(a1); st1_data = DW'(d1);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with stores driven
    mem_ready = 1'b1;
    drive(1'b1, 3, 11, 1'b1, 4, 22);
    repeat (3) cyc();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_st_ready", 64'(st_ready), 64'(1));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    idle();
    cyc();
    reset = 1'b1;
    cyc();

    // Two lanes, then one, drained back to back
    drive(1'b1, 15, 100, 1'b1, 16, 200);
    cyc();
    chk("t2_count_a", 64'(count), 64'(2));
    drive(1'b1, 17, 300, 1'b0, 0, 0);
    cyc();
    chk("t2_count_b", 64'(count), 64'(2));
    idle();
    cyc();
    chk("t2_count_c", 64'(count), 64'(1));
    cyc();
    chk("t2_count_d", 64'(count), 64'(0));
    cyc();

    // Fill, overflow, then drain
    mem_ready = 1'b0;
    drive(1'b1, 40, 1, 1'b1, 41, 2);
    cyc();
    drive(1'b1, 42, 3, 1'b1, 43, 4);
    cyc();
    chk("t3_full_count", 64'(count), 64'(4));
    chk("t3_st_ready", 64'(st_ready), 64'(0));
    drive(1'b1, 44, 5, 1'b0, 0, 0);
    cyc();
    idle();
    chk("t3_overflow", 64'(overflow), 64'(1));
    chk("t3_count_kept", 64'(count), 64'(4));
    mem_ready = 1'b1;
    repeat (6) cyc();

    // Same-address forwarding picks the younger store
    mem_ready = 1'b0;
    drive(1'b1, 15, 100, 1'b0, 0, 0);
    cyc();
    drive(1'b0, 0, 0, 1'b1, 15, 555);
    cyc();
    idle();
    ld0_addr = 10'd15;
    ld1_addr = 10'd16;
    #1;
    chk("t4_ld0_hit", 64'(ld0_hit), 64'(1));
    chk("t4_ld0_data", 64'(ld0_data), 64'(555));
    chk("t4_ld1_hit", 64'(ld1_hit), 64'(0));
    chk("t4_ld1_data", 64'(ld1_data), 64'(0));
    mem_ready = 1'b1;
    repeat (4) cyc();

    // Pointer wrap with single stores streaming through
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drive(1'b1, 100 + i, 1000 + i, 1'b0, 0, 0);
      else            drive(1'b0, 0, 0, 1'b1, 100 + i, 1000 + i);
      cyc();
      chk("t5_count_le1", 64'(count <= CW'(1)), 64'(1));
    end
    idle();
    repeat (3) cyc();

    // Reset with entries pending
    mem_ready = 1'b0;
    drive(1'b1, 60, 7, 1'b1, 61, 8);
    cyc();
    drive(1'b1, 62, 9, 1'b0, 0, 0);
    cyc();
    idle();
    chk("t6_count_pre", 64'(count), 64'(3));
    reset = 1'b0;
    #1;
    chk("t6_count", 64'(count), 64'(0));
    chk("t6_mem_we", 64'(mem_we), 64'(0));
    cyc();
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (5) cyc();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom));
      mem_ready = ($urandom_range(0, 9) < 6);
      ld0_addr  = AW'($urandom_range(0, 7));
      ld1_addr  = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) reset = 1'b0;
      else reset = 1'b1;
      cyc();
    end
    reset = 1'b1;
    idle();
    mem_ready = 1'b1;
    repeat (10) cyc();
    chk("final_drained", 64'(exp_wr.size()), 64'(0));
    chk("final_count", 64'(count), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
